// File: rtl/bicubic_window_fetch.sv
// Fetches the 4x4 source neighbourhood around an ROI-relative point from the
// image ROM, replicating edge pixels at the ROI border, and streams it out as
// four row beats (ky = 0..3) under valid/ready flow control.
//
// Ports:
//   CLK, RST_N                 clock (rising edge), async active-low reset
//   START, V0, H0, SW, SH      ROI configuration, latched by START in IDLE
//   REQ_VALID/REQ_READY        request handshake; REQ_X/REQ_Y centre point
//   ROM_RD, ROM_A, ROM_Q       synchronous ROM port, data one cycle after read
//   OUT_VALID/OUT_READY        row beat handshake
//   OUT_ROW, OUT_PX, OUT_LAST  beat row index, 4 pixels (kx0 in LSBs), last row
//   BUSY                       request in progress
module bicubic_window_fetch #(
    parameter int unsigned IMG_W = 100,
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            START,
    input  logic [6:0]      V0,
    input  logic [6:0]      H0,
    input  logic [4:0]      SW,
    input  logic [4:0]      SH,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [4:0]      REQ_X,
    input  logic [4:0]      REQ_Y,
    output logic            ROM_RD,
    output logic [AW-1:0]   ROM_A,
    input  logic [DW-1:0]   ROM_Q,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [1:0]      OUT_ROW,
    output logic [4*DW-1:0] OUT_PX,
    output logic            OUT_LAST,
    output logic            BUSY
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_CAPT, S_OUT} state_t;

    state_t          state;
    logic            cfg_ok;
    logic [6:0]      cfg_v0, cfg_h0, act_v0, act_h0;
    logic [4:0]      cfg_sw, cfg_sh, act_sw, act_sh;
    logic [4:0]      xs, ys;
    logic [1:0]      kx, ky, cap_kx;
    logic            rd_d;
    logic [4*DW-1:0] px;
    logic            req_ready, rom_rd, out_valid, out_last, busy;
    logic [1:0]      out_row;
    logic [AW-1:0]   rom_a;

    // Clamp c-1+k into [0, lim-1] using 7-bit signed arithmetic.
    function automatic logic [4:0] clamp_c(input logic [4:0] c, input logic [1:0] k,
                                           input logic [4:0] lim);
        logic signed [6:0] t, hi;
        t  = $signed({2'b00, c}) + $signed({5'b00000, k}) - 7'sd1;
        hi = $signed({2'b00, lim}) - 7'sd1;
        if (t < 7'sd0)     return 5'd0;
        else if (t > hi)   return hi[4:0];
        else               return t[4:0];
    endfunction

    function automatic logic [AW-1:0] win_addr(input logic [6:0] v0, input logic [6:0] h0,
                                               input logic [4:0] sw, input logic [4:0] sh,
                                               input logic [4:0] x,  input logic [4:0] y,
                                               input logic [1:0] k_x, input logic [1:0] k_y);
        logic [7:0] row, col;
        row = {1'b0, v0} + {3'b000, clamp_c(y, k_y, sh)};
        col = {1'b0, h0} + {3'b000, clamp_c(x, k_x, sw)};
        return AW'(AW'(row) * AW'(IMG_W)) + AW'(col);
    endfunction

    // Saturated request point and the addresses needed at the next edge.
    logic [4:0]    req_xs_c, req_ys_c;
    logic [1:0]    nxt_kx_c, nxt_ky_c;
    logic [AW-1:0] first_addr_c, next_addr_c;

    always_comb begin
        req_xs_c = (REQ_X > cfg_sw - 5'd1) ? cfg_sw - 5'd1 : REQ_X;
        req_ys_c = (REQ_Y > cfg_sh - 5'd1) ? cfg_sh - 5'd1 : REQ_Y;
        nxt_kx_c = (state == S_OUT) ? 2'd0 : kx + 2'd1;
        nxt_ky_c = (state == S_OUT) ? ky + 2'd1 : ky;
        first_addr_c = win_addr(cfg_v0, cfg_h0, cfg_sw, cfg_sh, req_xs_c, req_ys_c, 2'd0, 2'd0);
        next_addr_c  = win_addr(act_v0, act_h0, act_sw, act_sh, xs, ys, nxt_kx_c, nxt_ky_c);
    end

    // Control FSM with registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cfg_ok    <= 1'b0;
            cfg_v0    <= '0;
            cfg_h0    <= '0;
            cfg_sw    <= '0;
            cfg_sh    <= '0;
            act_v0    <= '0;
            act_h0    <= '0;
            act_sw    <= '0;
            act_sh    <= '0;
            xs        <= '0;
            ys        <= '0;
            kx        <= '0;
            ky        <= '0;
            cap_kx    <= '0;
            rd_d      <= 1'b0;
            px        <= '0;
            req_ready <= 1'b0;
            rom_rd    <= 1'b0;
            rom_a     <= '0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // ROM data returns one cycle after issue; slot follows the issued kx.
            rd_d   <= rom_rd;
            cap_kx <= kx;
            if (rd_d) px[DW*int'(cap_kx) +: DW] <= ROM_Q;

            case (state)
                S_IDLE: begin
                    if (START) begin
                        cfg_v0    <= V0;
                        cfg_h0    <= H0;
                        cfg_sw    <= SW;
                        cfg_sh    <= SH;
                        cfg_ok    <= 1'b1;
                        req_ready <= 1'b1;
                    end
                    // Accept uses the pre-START configuration; it is snapshotted here.
                    if (REQ_VALID && req_ready) begin
                        act_v0    <= cfg_v0;
                        act_h0    <= cfg_h0;
                        act_sw    <= cfg_sw;
                        act_sh    <= cfg_sh;
                        xs        <= req_xs_c;
                        ys        <= req_ys_c;
                        kx        <= 2'd0;
                        ky        <= 2'd0;
                        rom_a     <= first_addr_c;
                        rom_rd    <= 1'b1;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (kx == 2'd3) begin
                        rom_rd <= 1'b0;
                        state  <= S_CAPT;
                    end else begin
                        kx    <= nxt_kx_c;
                        rom_a <= next_addr_c;
                    end
                end
                S_CAPT: begin
                    out_valid <= 1'b1;
                    out_row   <= ky;
                    out_last  <= (ky == 2'd3);
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (OUT_READY) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (ky == 2'd3) begin
                            busy      <= 1'b0;
                            req_ready <= cfg_ok;
                            state     <= S_IDLE;
                        end else begin
                            kx     <= nxt_kx_c;
                            ky     <= nxt_ky_c;
                            rom_a  <= next_addr_c;
                            rom_rd <= 1'b1;
                            state  <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign REQ_READY = req_ready;
    assign ROM_RD    = rom_rd;
    assign ROM_A     = rom_a;
    assign OUT_VALID = out_valid;
    assign OUT_ROW   = out_row;
    assign OUT_PX    = px;
    assign OUT_LAST  = out_last;
    assign BUSY      = busy;

endmodule

// File: tb/tb_bicubic_window_fetch.sv
module tb_bicubic_window_fetch;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        START = 1'b0;
    logic [6:0]  V0 = '0, H0 = '0;
    logic [4:0]  SW = '0, SH = '0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [4:0]  REQ_X = '0, REQ_Y = '0;
    logic        ROM_RD;
    logic [13:0] ROM_A;
    logic [7:0]  ROM_Q = '0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [1:0]  OUT_ROW;
    logic [31:0] OUT_PX;
    logic        OUT_LAST;
    logic        BUSY;

    bicubic_window_fetch dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .V0(V0), .H0(H0), .SW(SW), .SH(SH),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_X(REQ_X), .REQ_Y(REQ_Y),
        .ROM_RD(ROM_RD), .ROM_A(ROM_A), .ROM_Q(ROM_Q),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_ROW(OUT_ROW),
        .OUT_PX(OUT_PX), .OUT_LAST(OUT_LAST), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  row;
        logic [31:0] px;
        logic        last;
    } beat_t;

    int    addr_q[$];
    beat_t beat_q[$];
    int    obs[16];
    int    obs_n = 0;
    int    cur_v0, cur_h0, cur_sw, cur_sh;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pix(input int a);
        return 8'((a * 37 + (a >> 5)) & 255);
    endfunction

    function automatic int m_coord(input int c, input int k, input int lim);
        int t;
        t = c - 1 + k;
        if (t < 0) t = 0;
        if (t > lim - 1) t = lim - 1;
        return t;
    endfunction

    // Reference model: push expected read addresses and row beats.
    task automatic push_req(input int x, input int y);
        int xs, ys, a;
        beat_t b;
        xs = (x > cur_sw - 1) ? cur_sw - 1 : x;
        ys = (y > cur_sh - 1) ? cur_sh - 1 : y;
        for (int ky = 0; ky < 4; ky++) begin
            b.row  = 2'(ky);
            b.last = (ky == 3);
            b.px   = '0;
            for (int kx = 0; kx < 4; kx++) begin
                a = (cur_v0 + m_coord(ys, ky, cur_sh)) * 100 + cur_h0 + m_coord(xs, kx, cur_sw);
                addr_q.push_back(a);
                b.px[8*kx +: 8] = pix(a);
            end
            beat_q.push_back(b);
        end
    endtask

    // Synchronous ROM model.
    always @(posedge CLK) if (ROM_RD) ROM_Q <= pix(int'(ROM_A));

    // Scoreboard monitor, sampling away from the active edge.
    always @(negedge CLK) begin
        int    e;
        beat_t b;
        if (RST_N) begin
            if (ROM_RD) begin
                chk("rd_expected", 64'(addr_q.size() != 0), 64'd1);
                if (addr_q.size() != 0) begin
                    e = addr_q.pop_front();
                    chk("rom_a", 64'(ROM_A), 64'(e));
                end
                if (obs_n < 16) obs[obs_n] = int'(ROM_A);
                obs_n++;
            end
            chk("out_last_rule", 64'(OUT_LAST), 64'(OUT_VALID && OUT_ROW == 2'd3));
            if (OUT_VALID && OUT_READY) begin
                chk("beat_expected", 64'(beat_q.size() != 0), 64'd1);
                if (beat_q.size() != 0) begin
                    b = beat_q.pop_front();
                    chk("out_row", 64'(OUT_ROW), 64'(b.row));
                    chk("out_px", 64'(OUT_PX), 64'(b.px));
                    chk("out_last", 64'(OUT_LAST), 64'(b.last));
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!REQ_READY && t < 100) begin step(); t++; end
        chk("ready_wait", 64'(REQ_READY), 64'd1);
    endtask

    task automatic configure(input int v0, input int h0, input int sw, input int sh);
        V0 = 7'(v0); H0 = 7'(h0); SW = 5'(sw); SH = 5'(sh);
        START = 1'b1;
        step();
        START = 1'b0;
        cur_v0 = v0; cur_h0 = h0; cur_sw = sw; cur_sh = sh;
        chk("ready_after_start", 64'(REQ_READY), 64'd1);
    endtask

    // mode 0: plain; 1: START with H0=50 while busy; 2: START with H0=30 on accept edge.
    task automatic do_req(input int x, input int y, input int mode);
        int n;
        wait_ready();
        obs_n = 0;
        push_req(x, y);
        REQ_X = 5'(x); REQ_Y = 5'(y); REQ_VALID = 1'b1;
        if (mode == 2) begin START = 1'b1; H0 = 7'd30; end
        step();
        REQ_VALID = 1'b0;
        START = 1'b0;
        if (mode == 2) cur_h0 = 30;
        n = 1;
        chk("rd_cycle1", 64'(ROM_RD), 64'd1);
        chk("busy_cycle1", 64'(BUSY), 64'd1);
        chk("ready_low_cycle1", 64'(REQ_READY), 64'd0);
        if (mode == 1) begin
            START = 1'b1; H0 = 7'd50;
            step(); n++;
            START = 1'b0;
        end
        while (!OUT_VALID && n < 40) begin step(); n++; end
        chk("first_valid_cycle", 64'(n), 64'd6);
        while (!REQ_READY && n < 200) begin step(); n++; end
        chk("edges_to_ready", 64'(n - 1), 64'd24);
        chk("beats_left", 64'(beat_q.size()), 64'd0);
        chk("reads_done", 64'(obs_n), 64'd16);
    endtask

    typedef struct {
        int v0, h0, sw, sh, x, y;
        int first_a, last_a;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int t;
        logic [31:0] save_px;

        vt[0] = '{10, 20, 8, 8, 3, 3, 1222, 1525};
        vt[1] = '{10, 20, 8, 8, 0, 0, 1020, 1222};
        vt[2] = '{10, 20, 8, 8, 7, 7, 1626, 1727};
        vt[3] = '{10, 20, 8, 8, 20, 25, 1626, 1727};
        vt[4] = '{99, 99, 1, 1, 5, 5, 9999, 9999};
        vt[5] = '{50, 60, 31, 1, 30, 0, 5089, 5090};
        vt[6] = '{69, 69, 31, 31, 15, 0, 6983, 7186};

        #2 RST_N = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req_ready", 64'(REQ_READY), 64'd0);
        chk("rst_rom_rd", 64'(ROM_RD), 64'd0);
        chk("rst_rom_a", 64'(ROM_A), 64'd0);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_out_px", 64'(OUT_PX), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        RST_N = 1'b1;

        // No configuration yet: requests are not accepted.
        REQ_VALID = 1'b1;
        repeat (5) begin
            step();
            chk("precfg_ready", 64'(REQ_READY), 64'd0);
            chk("precfg_busy", 64'(BUSY), 64'd0);
        end
        REQ_VALID = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (i == 0 || vt[i].v0 != cur_v0 || vt[i].h0 != cur_h0 ||
                vt[i].sw != cur_sw || vt[i].sh != cur_sh)
                configure(vt[i].v0, vt[i].h0, vt[i].sw, vt[i].sh);
            do_req(vt[i].x, vt[i].y, 0);
            chk("vec_first_addr", 64'(obs[0]), 64'(vt[i].first_a));
            chk("vec_last_addr", 64'(obs[15]), 64'(vt[i].last_a));
        end

        // Backpressure on the row-1 beat.
        configure(10, 20, 8, 8);
        OUT_READY = 1'b0;
        wait_ready();
        obs_n = 0;
        push_req(3, 3);
        REQ_X = 5'd3; REQ_Y = 5'd3; REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        t = 0;
        while (!OUT_VALID && t < 40) begin step(); t++; end
        chk("bp_row0_valid", 64'(OUT_VALID), 64'd1);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        t = 0;
        while (!OUT_VALID && t < 40) begin step(); t++; end
        chk("bp_row1_row", 64'(OUT_ROW), 64'd1);
        save_px = OUT_PX;
        repeat (10) begin
            step();
            chk("bp_valid_hold", 64'(OUT_VALID), 64'd1);
            chk("bp_px_stable", 64'(OUT_PX), 64'(save_px));
            chk("bp_row_stable", 64'(OUT_ROW), 64'd1);
            chk("bp_rom_rd", 64'(ROM_RD), 64'd0);
            chk("bp_req_ready", 64'(REQ_READY), 64'd0);
        end
        OUT_READY = 1'b1;
        step();
        chk("bp_row2_rd", 64'(ROM_RD), 64'd1);
        chk("bp_row2_addr", 64'(ROM_A), 64'd1422);
        wait_ready();
        chk("bp_beats_left", 64'(beat_q.size()), 64'd0);

        // START while busy is ignored, both for this window and the next.
        do_req(3, 3, 1);
        chk("busy_start_cur", 64'(obs[0]), 64'd1222);
        do_req(3, 3, 0);
        chk("busy_start_next", 64'(obs[0]), 64'd1222);

        // START on the accept edge: old config now, new config afterwards.
        do_req(3, 3, 2);
        chk("co_start_cur", 64'(obs[0]), 64'd1222);
        do_req(3, 3, 0);
        chk("co_start_next", 64'(obs[0]), 64'd1232);

        // Reset during the second FETCH cycle.
        wait_ready();
        push_req(3, 3);
        REQ_X = 5'd3; REQ_Y = 5'd3; REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        step();
        chk("pre_rst_fetch", 64'(ROM_RD), 64'd1);
        RST_N = 1'b0;
        #1;
        chk("arst_rom_rd", 64'(ROM_RD), 64'd0);
        chk("arst_rom_a", 64'(ROM_A), 64'd0);
        chk("arst_busy", 64'(BUSY), 64'd0);
        chk("arst_req_ready", 64'(REQ_READY), 64'd0);
        chk("arst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("arst_out_px", 64'(OUT_PX), 64'd0);
        addr_q.delete();
        beat_q.delete();
        repeat (2) @(posedge CLK);
        #1 RST_N = 1'b1;
        REQ_VALID = 1'b1;
        repeat (30) begin
            step();
            chk("post_rst_ready", 64'(REQ_READY), 64'd0);
            chk("post_rst_valid", 64'(OUT_VALID), 64'd0);
        end
        REQ_VALID = 1'b0;

        // Recovery after reconfiguration.
        configure(10, 20, 8, 8);
        do_req(7, 7, 0);
        chk("recover_last", 64'(obs[15]), 64'd1727);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
